// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states and the mode constants
// that the master, the slave and their benches agree on.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    localparam bit SPI_CPOL      = 1'b0;
    localparam bit SPI_CPHA      = 1'b0;
    localparam bit SPI_MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_master_if.sv
// Word-level handshake between user logic and the SPI engine.
// The engine takes the slave modport, user logic the master one.
interface spi_master_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] data_in;
    logic             data_in_valid;
    logic [WIDTH-1:0] data_out;
    logic             data_out_valid;
    logic             busy;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_out,
        input  data_out_valid,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_out,
        output data_out_valid,
        output busy
    );

endinterface

// File: rtl/spi_clk_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while
// enabled; reloads whenever disabled so each frame starts aligned.
module spi_clk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == '0);

    // Down-count to zero, reload on tick or while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en_i || tick_o) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one accepted word becomes one CS-framed,
// full-duplex, MSB-first transfer followed by a CS-high gap.
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    spi_master_if.slave bus,
    output logic       sck,
    output logic       cs,
    output logic       mosi,
    input  logic       miso
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("spi_master: CLK_DIV must be >= 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("spi_master: WIDTH must be >= 2");
    end

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BITS = BW'(WIDTH);

    spi_state_e       state_q;
    logic [WIDTH-1:0] tx_q;
    logic [WIDTH-1:0] rx_q;
    logic [WIDTH-1:0] dout_q;
    logic [BW-1:0]    bit_q;
    logic             sck_q;
    logic             cs_q;
    logic             mosi_q;
    logic             busy_q;
    logic             dv_q;
    logic             miso_q;
    logic             samp_q;
    logic             tick;

    spi_clk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != IDLE),
        .tick_o (tick)
    );

    assign sck                = sck_q;
    assign cs                 = cs_q;
    assign mosi               = mosi_q;
    assign bus.busy           = busy_q;
    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dv_q;

    // Single register stage on the asynchronous slave output.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= miso;
        end
    end

    // Transfer FSM; samp_q delays the receive shift one cycle
    // past each SCK rise so it uses the registered MISO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            samp_q  <= 1'b0;
        end else begin
            dv_q   <= 1'b0;
            samp_q <= 1'b0;
            if (samp_q) begin
                rx_q <= {rx_q[WIDTH-2:0], miso_q};
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.data_in_valid) begin
                        tx_q    <= bus.data_in;
                        mosi_q  <= bus.data_in[WIDTH-1];
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        samp_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (sck_q) begin
                            sck_q  <= 1'b0;
                            bit_q  <= bit_q + 1'b1;
                            tx_q   <= {tx_q[WIDTH-2:0], 1'b0};
                            mosi_q <= tx_q[WIDTH-2];
                        end else if (bit_q == BITS) begin
                            state_q <= HOLD;
                        end else begin
                            sck_q  <= 1'b1;
                            samp_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_q    <= 1'b1;
                        dout_q  <= rx_q;
                        dv_q    <= 1'b1;
                        mosi_q  <= 1'b0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a CLK_DIV=4 instance with
// loopback or a behavioural slave, and a CLK_DIV=2 loopback.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       dval;
    logic       sel;
    logic       lb;

    logic sck1, cs1, mosi1, miso1;
    logic sck2, cs2, mosi2;

    spi_master_if #(.WIDTH(8)) if1 ();
    spi_master_if #(.WIDTH(8)) if2 ();

    assign if1.data_in       = din;
    assign if1.data_in_valid = dval && !sel;
    assign if2.data_in       = din;
    assign if2.data_in_valid = dval && sel;

    logic [7:0] s_tx;
    logic [7:0] s_rx;
    logic       s_miso;

    assign s_miso = s_tx[7];
    assign miso1  = lb ? mosi1 : s_miso;

    spi_master #(.WIDTH(8), .CLK_DIV(4)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if1),
        .sck  (sck1),
        .cs   (cs1),
        .mosi (mosi1),
        .miso (miso1)
    );

    spi_master #(.WIDTH(8), .CLK_DIV(2)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .bus  (if2),
        .sck  (sck2),
        .cs   (cs2),
        .mosi (mosi2),
        .miso (mosi2)
    );

    always #5 clk = ~clk;

    // Behavioural mode-0 slave that answers 0x3C
    initial begin
        s_tx = 8'h00;
        s_rx = 8'h00;
    end
    always @(negedge cs1) begin
        s_tx = 8'h3C;
        s_rx = 8'h00;
    end
    always @(posedge sck1) if (!cs1) s_rx = {s_rx[6:0], mosi1};
    always @(negedge sck1) if (!cs1) s_tx = {s_tx[6:0], 1'b0};

    logic       m_sck, m_cs, m_busy, m_dv, m_mosi;
    logic [7:0] m_dout;

    assign m_sck  = sel ? sck2 : sck1;
    assign m_cs   = sel ? cs2 : cs1;
    assign m_mosi = sel ? mosi2 : mosi1;
    assign m_busy = sel ? if2.busy : if1.busy;
    assign m_dv   = sel ? if2.data_out_valid : if1.data_out_valid;
    assign m_dout = sel ? if2.data_out : if1.data_out;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc, rel;
    int rises, r1, r2, dvs, dv1_rel, dv2_rel;
    int cs_low, csf, csf_rel, busy_cnt, bfall;
    logic [7:0] dv1_dat, dv2_dat;
    logic sck_p, cs_p, busy_p;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        rises = 0; r1 = 0; r2 = 0; dvs = 0;
        dv1_rel = 0; dv2_rel = 0; dv1_dat = 0; dv2_dat = 0;
        cs_low = 0; csf = 0; csf_rel = 0; busy_cnt = 0; bfall = 0;
        sck_p = m_sck; cs_p = m_cs; busy_p = m_busy;
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - acc + 1;
        if (m_sck && !sck_p) begin
            rises++;
            if (rises == 1) r1 = rel;
            if (rises == 2) r2 = rel;
        end
        if (m_dv) begin
            dvs++;
            if (dvs == 1) begin
                dv1_rel = rel; dv1_dat = m_dout;
            end else begin
                dv2_rel = rel; dv2_dat = m_dout;
            end
        end
        if (!m_cs) cs_low++;
        if (cs_p && !m_cs) begin
            csf++; csf_rel = rel;
        end
        if (m_busy) busy_cnt++;
        if (busy_p && !m_busy && bfall == 0) bfall = rel;
        sck_p = m_sck; cs_p = m_cs; busy_p = m_busy;
    endtask

    task automatic start(input logic [7:0] d);
        din = d;
        dval = 1'b1;
        clear();
        acc = cyc + 1;
        tick1();
        dval = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int done;
        done = 0;
        for (int i = 0; i < bound && done == 0; i++) begin
            tick1();
            if (!m_busy) done = 1;
        end
        if (done == 0) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; din = 8'h00; dval = 1'b0; sel = 1'b0; lb = 1'b1;
        acc = 0;
        clear();
        repeat (3) tick1();
        rst = 1'b0;
        tick1();

        chk("rst_cs1", cs1, 1);
        chk("rst_sck1", sck1, 0);
        chk("rst_mosi1", mosi1, 0);
        chk("rst_busy1", if1.busy, 0);
        chk("rst_dout1", if1.data_out, 0);
        chk("rst_dv1", if1.data_out_valid, 0);
        chk("rst_cs2", cs2, 1);
        chk("rst_sck2", sck2, 0);
        chk("rst_busy2", if2.busy, 0);
        chk("rst_dout2", if2.data_out, 0);

        // Loopback 0xA5
        start(8'hA5);
        chk("lb_cs_c1", m_cs, 0);
        chk("lb_busy_c1", m_busy, 1);
        chk("lb_mosi_c1", m_mosi, 1);
        wait_idle(200);
        chk("lb_dout", m_dout, 8'hA5);
        chk("lb_dv_cnt", dvs, 1);
        chk("lb_dv_cyc", dv1_rel, 73);
        chk("lb_rises", rises, 8);
        chk("lb_rise0", r1, 5);
        chk("lb_busy_fall", bfall, 77);
        chk("lb_cs_low", cs_low, 72);

        // Behavioural slave exchange
        lb = 1'b0;
        tick1();
        start(8'h81);
        wait_idle(200);
        chk("sl_model_rx", s_rx, 8'h81);
        chk("sl_dout", dv1_dat, 8'h3C);
        chk("sl_cs_low", cs_low, 72);
        lb = 1'b1;
        tick1();

        // Back-to-back with data_in_valid held high
        start(8'h01);
        din = 8'h02;
        dval = 1'b1;
        for (int i = 0; i < 400 && !(dvs == 2 && !m_busy); i++) begin
            tick1();
            if (csf == 2) dval = 1'b0;
        end
        dval = 1'b0;
        chk("b2b_dv_cnt", dvs, 2);
        chk("b2b_d0", dv1_dat, 8'h01);
        chk("b2b_d1", dv2_dat, 8'h02);
        chk("b2b_dv1_cyc", dv2_rel, 150);
        chk("b2b_gap", csf_rel - dv1_rel, 5);
        tick1();

        // Request while busy is dropped
        start(8'h10);
        for (int i = 0; i < 18; i++) tick1();
        din = 8'hFF;
        dval = 1'b1;
        tick1();
        dval = 1'b0;
        wait_idle(200);
        chk("rwb_dout", m_dout, 8'h10);
        chk("rwb_dv_cnt", dvs, 1);
        chk("rwb_busy_fall", bfall, 77);
        chk("rwb_cs_falls", csf, 1);
        repeat (10) tick1();
        chk("rwb_no_2nd", m_busy, 0);

        // Reset mid-transfer, with a request colliding with reset
        start(8'hE7);
        for (int i = 0; i < 29; i++) tick1();
        rst = 1'b1;
        din = 8'h77;
        dval = 1'b1;
        tick1();
        rst = 1'b0;
        dval = 1'b0;
        chk("mid_cs", m_cs, 1);
        chk("mid_sck", m_sck, 0);
        chk("mid_busy", m_busy, 0);
        chk("mid_mosi", m_mosi, 0);
        chk("mid_dout", m_dout, 0);
        repeat (10) tick1();
        chk("mid_no_dv", dvs, 0);
        chk("mid_dropped", m_busy, 0);
        start(8'h5A);
        wait_idle(200);
        chk("mid_new_dout", m_dout, 8'h5A);
        chk("mid_new_dv", dv1_rel, 73);

        // Minimum divider
        sel = 1'b1;
        tick1();
        start(8'hC3);
        wait_idle(200);
        chk("min_dout", m_dout, 8'hC3);
        chk("min_busy_len", busy_cnt, 38);
        chk("min_period", r2 - r1, 4);
        chk("min_rises", rises, 8);
        chk("min_dv_cyc", dv1_rel, 37);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
